// File: rtl/vp_kbd_pkg.sv
// Shared constants, key-position type, decoder state enum and the PS/2 set-2
// scancode tables for the PS/2-to-console keyboard matrix bridge.
package vp_kbd_pkg;

  localparam int ROWS = 6;
  localparam int COLS = 8;
  localparam int KEYS = ROWS * COLS;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_BAT  = 8'hAA;
  localparam logic [7:0] SC_OVR0 = 8'h00;
  localparam logic [7:0] SC_OVR1 = 8'hFF;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic       vld;
  } key_pos_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    E0   = 2'd1,
    F0   = 2'd2,
    E0F0 = 2'd3
  } dec_state_t;

  function automatic key_pos_t kp(input logic [2:0] r, input logic [2:0] c);
    key_pos_t p;
    p.row = r;
    p.col = c;
    p.vld = 1'b1;
    return p;
  endfunction

  function automatic key_pos_t std_lookup(input logic [7:0] code);
    key_pos_t p;
    p = '0;
    case (code)
      8'h45: p = kp(3'd0, 3'd0);  8'h16: p = kp(3'd0, 3'd1);
      8'h1E: p = kp(3'd0, 3'd2);  8'h26: p = kp(3'd0, 3'd3);
      8'h25: p = kp(3'd0, 3'd4);  8'h2E: p = kp(3'd0, 3'd5);
      8'h36: p = kp(3'd0, 3'd6);  8'h3D: p = kp(3'd0, 3'd7);
      8'h3E: p = kp(3'd1, 3'd0);  8'h46: p = kp(3'd1, 3'd1);
      8'h1C: p = kp(3'd1, 3'd2);  8'h32: p = kp(3'd1, 3'd3);
      8'h21: p = kp(3'd1, 3'd4);  8'h23: p = kp(3'd1, 3'd5);
      8'h24: p = kp(3'd1, 3'd6);  8'h2B: p = kp(3'd1, 3'd7);
      8'h34: p = kp(3'd2, 3'd0);  8'h33: p = kp(3'd2, 3'd1);
      8'h43: p = kp(3'd2, 3'd2);  8'h3B: p = kp(3'd2, 3'd3);
      8'h42: p = kp(3'd2, 3'd4);  8'h4B: p = kp(3'd2, 3'd5);
      8'h3A: p = kp(3'd2, 3'd6);  8'h31: p = kp(3'd2, 3'd7);
      8'h44: p = kp(3'd3, 3'd0);  8'h4D: p = kp(3'd3, 3'd1);
      8'h15: p = kp(3'd3, 3'd2);  8'h2D: p = kp(3'd3, 3'd3);
      8'h1B: p = kp(3'd3, 3'd4);  8'h2C: p = kp(3'd3, 3'd5);
      8'h3C: p = kp(3'd3, 3'd6);  8'h2A: p = kp(3'd3, 3'd7);
      8'h1D: p = kp(3'd4, 3'd0);  8'h22: p = kp(3'd4, 3'd1);
      8'h35: p = kp(3'd4, 3'd2);  8'h1A: p = kp(3'd4, 3'd3);
      8'h12: p = kp(3'd4, 3'd4);  8'h14: p = kp(3'd4, 3'd5);
      8'h11: p = kp(3'd4, 3'd6);  8'h76: p = kp(3'd4, 3'd7);
      8'h0D: p = kp(3'd5, 3'd0);  8'h66: p = kp(3'd5, 3'd1);
      8'h29: p = kp(3'd5, 3'd2);  8'h05: p = kp(3'd5, 3'd3);
      8'h06: p = kp(3'd5, 3'd4);  8'h04: p = kp(3'd5, 3'd5);
      8'h0C: p = kp(3'd5, 3'd6);  8'h5A: p = kp(3'd5, 3'd7);
      default: p = '0;
    endcase
    return p;
  endfunction

  // Cursor keys share the F1..F4 positions; right Ctrl/Alt alias the left ones.
  function automatic key_pos_t ext_lookup(input logic [7:0] code);
    key_pos_t p;
    p = '0;
    case (code)
      8'h75: p = kp(3'd5, 3'd3);
      8'h72: p = kp(3'd5, 3'd4);
      8'h6B: p = kp(3'd5, 3'd5);
      8'h74: p = kp(3'd5, 3'd6);
      8'h14: p = kp(3'd4, 3'd5);
      8'h11: p = kp(3'd4, 3'd6);
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vp_ps2_matrix_if.sv
// Scancode byte stream handshake into the keyboard matrix bridge.
interface vp_ps2_matrix_if;
  logic [7:0] scan_i;
  logic       scan_vld_i;
  logic       scan_rdy_o;

  modport master (output scan_i, output scan_vld_i, input scan_rdy_o);
  modport slave  (input scan_i, input scan_vld_i, output scan_rdy_o);
endinterface

// File: rtl/vp_kbd_lut.sv
// Registered scancode-to-matrix-position lookup, one cycle latency.
// Extended codes resolve only when VP_KBD_EXT_KEYS_EN is defined.
module vp_kbd_lut
  import vp_kbd_pkg::*;
(
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic       vld_p0,
  input  logic [7:0] code_p0,
  input  logic       ext_p0,
  output logic       vld_p1,
  output key_pos_t   pos_p1
);

  key_pos_t pos_nxt;

  always_comb begin
    pos_nxt = '0;
`ifdef VP_KBD_EXT_KEYS_EN
    pos_nxt = ext_p0 ? ext_lookup(code_p0) : std_lookup(code_p0);
`else
    pos_nxt = ext_p0 ? key_pos_t'('0) : std_lookup(code_p0);
`endif
  end

  // p0 -> p1
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) vld_p1 <= 1'b0;
    else          vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk_i) begin
    pos_p1 <= pos_nxt;
  end

endmodule

// File: rtl/vp_ps2_matrix.sv
// PS/2 set-2 scancode decoder driving a 6x8 console keyboard matrix.
// Define VP_KBD_EXT_KEYS_EN to map E0-prefixed keys onto the matrix.
module vp_ps2_matrix
  import vp_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 21477
)(
  input  logic                 clk_i,
  input  logic                 res_n_i,
  vp_ps2_matrix_if.slave       scan_if,
  input  logic [ROWS-1:0]      keyb_dec_i,
  output logic [COLS-1:0]      keyb_enc_o,
  output logic [KEYS-1:0]      matrix_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dec_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic [7:0]       scan;
  logic             evt_vld, evt_ext, evt_brk, evt_clr;

  logic             busy_p0, vld_p0, clr_p0, ext_p0, brk_p0;
  logic [7:0]       code_p0;
  logic             busy_p1, vld_p1, clr_p1, brk_p1;
  key_pos_t         pos_p1;
  logic [KEYS-1:0]  matrix_q;

  assign scan               = scan_if.scan_i;
  assign scan_if.scan_rdy_o = ~(busy_p0 | busy_p1);
  assign accept             = scan_if.scan_vld_i & scan_if.scan_rdy_o;

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept || state == IDLE || cnt == CNT_LAST) cnt <= '0;
      else                                            cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        IDLE:    if (scan == SC_EXT)      state_nxt = E0;
                 else if (scan == SC_BRK) state_nxt = F0;
        E0:      state_nxt = (scan == SC_BRK) ? E0F0 : IDLE;
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE && cnt == CNT_LAST) begin
      state_nxt = IDLE;
    end
  end

  // Reset-report (AA) and overrun (00/FF) only count as such outside a prefix.
  always_comb begin
    evt_vld = 1'b0;
    evt_ext = 1'b0;
    evt_brk = 1'b0;
    evt_clr = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (scan == SC_BAT || scan == SC_OVR0 || scan == SC_OVR1) evt_clr = 1'b1;
          else if (scan != SC_EXT && scan != SC_BRK)                evt_vld = 1'b1;
        end
        E0: begin
          evt_vld = (scan != SC_BRK);
          evt_ext = 1'b1;
        end
        F0: begin
          evt_vld = 1'b1;
          evt_brk = 1'b1;
        end
        default: begin
          evt_vld = 1'b1;
          evt_ext = 1'b1;
          evt_brk = 1'b1;
        end
      endcase
    end
  end

  // accept -> p0
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      busy_p0 <= 1'b0;
      vld_p0  <= 1'b0;
      clr_p0  <= 1'b0;
    end else begin
      busy_p0 <= accept;
      vld_p0  <= evt_vld;
      clr_p0  <= evt_clr;
    end
  end

  always_ff @(posedge clk_i) begin
    code_p0 <= scan;
    ext_p0  <= evt_ext;
    brk_p0  <= evt_brk;
  end

  vp_kbd_lut u_lut (
    .clk_i   (clk_i),
    .res_n_i (res_n_i),
    .vld_p0  (vld_p0),
    .code_p0 (code_p0),
    .ext_p0  (ext_p0),
    .vld_p1  (vld_p1),
    .pos_p1  (pos_p1)
  );

  // p0 -> p1
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      busy_p1 <= 1'b0;
      clr_p1  <= 1'b0;
    end else begin
      busy_p1 <= busy_p0;
      clr_p1  <= clr_p0;
    end
  end

  always_ff @(posedge clk_i) begin
    brk_p1 <= brk_p0;
  end

  // p1 -> matrix state
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      matrix_q <= '0;
    end else if (clr_p1) begin
      matrix_q <= '0;
    end else if (vld_p1 && pos_p1.vld) begin
      matrix_q[{pos_p1.row, pos_p1.col}] <= ~brk_p1;
    end
  end

  assign matrix_o = matrix_q;

  always_comb begin
    keyb_enc_o = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (!keyb_dec_i[r]) keyb_enc_o = keyb_enc_o & ~matrix_q[r*COLS +: COLS];
    end
  end

endmodule

// File: doc/vp_ps2_matrix.md
VP_PS2_MATRIX -- requirements
Module: vp_ps2_matrix

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 21477: clk_i cycles allowed between a prefix byte and its follow-up (1 ms at 21.477 MHz).
REQ-002 SHALL have ports: clk_i  in  1  system clock, 21.477 MHz.
REQ-003 SHALL have ports: res_n_i  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: scan_i  in  8  raw PS/2 set-2 scancode byte.
REQ-005 SHALL have ports: scan_vld_i  in  1  scan_i valid.
REQ-006 SHALL have ports: scan_rdy_o  out  1  block accepts a byte this cycle.
REQ-007 SHALL have ports: keyb_dec_i  in  6  row select from console, index 1..6, active-low.
REQ-008 SHALL have ports: keyb_enc_o  out  8  column return to console, index 7..14, active-low.
REQ-009 SHALL have ports: matrix_o  out  48  held-key state, bit row*8+col, 1 = pressed (debug/overlay).

Function
REQ-010 SHALL accept a byte only on a clk_i edge where scan_vld_i and scan_rdy_o are both 1.
REQ-011 SHALL drive scan_rdy_o 0 for exactly the 2 cycles after an accept (lookup + update), then 1.
REQ-012 SHALL have decoder FSM states IDLE, E0, F0, E0F0.
- IDLE: byte E0 -> E0; F0 -> F0; other -> make event, stay IDLE.
- E0: F0 -> E0F0; other -> extended make event, go IDLE.
- F0: any -> break event, go IDLE.
- E0F0: any -> extended break event, go IDLE.
REQ-013 SHALL return to IDLE with no event when TIMEOUT_CYCLES cycles pass in E0, F0 or E0F0 without an accept.
REQ-014 SHALL, when a byte with value AA (self-test pass) or 00/FF (overrun) is accepted in IDLE, clear all 48 key bits and generate no event.
REQ-015 SHALL map each event through a scancode-to-(row,col) table; unmapped codes generate no state change.
REQ-016 SHALL set the mapped bit on make and clear it on break; the matrix update occurs 2 cycles after the accept edge.
REQ-017 SHALL leave the key bit unchanged when a repeated make (typematic) arrives for a key already pressed.
REQ-018 SHALL drive keyb_enc_o[c] low iff any row r with keyb_dec_i[r] low has a pressed key in column c; the path from keyb_dec_i to keyb_enc_o is combinational.
REQ-019 SHALL drive keyb_enc_o all 1 when keyb_dec_i is all 1; multiple low rows SHALL OR their columns.

Reset
REQ-020 SHALL, while res_n_i is low, force FSM IDLE, timeout counter 0, all key bits 0, pipeline empty, scan_rdy_o 1, keyb_enc_o 8'hFF, matrix_o 0.
REQ-021 SHALL discard a byte accepted in the cycle reset asserts, including any in-flight lookup.

Configuration
REQ-022 SHALL, with VP_KBD_EXT_KEYS_EN defined, map extended (E0) events through the extended table (cursor keys onto matrix positions).
REQ-023 SHALL, without VP_KBD_EXT_KEYS_EN, consume E0 sequences fully per REQ-012 and generate no state change.

Structure
REQ-024 SHALL place the ROWS=6/COLS=8 constants, the key-position typedef (row 3 bits, col 3 bits, valid 1 bit), the FSM state enum and both lookup tables in package vp_kbd_pkg.
REQ-025 SHALL implement the registered table lookup as sub-module vp_kbd_lut (scancode + extended flag in, key position out, 1-cycle latency).

Verification
REQ-026 SHALL cover: reset, then byte 16 -> matrix_o bit 1 set on the 2nd cycle after accept; keyb_dec_i=6'b111110 -> keyb_enc_o=8'b11111101.
REQ-027 SHALL cover: bytes F0,16 after REQ-026 -> bit 1 cleared; keyb_enc_o=8'hFF for every keyb_dec_i value.
REQ-028 SHALL cover: keys 45 (row0 col0) and 5A (row5 col7) held, keyb_dec_i=6'b011110 -> keyb_enc_o=8'b01111110.
REQ-029 SHALL cover: byte F0 followed by TIMEOUT_CYCLES idle cycles, then 16 -> make event (not a break); bit 1 set.
REQ-030 SHALL cover: three keys held, byte AA -> matrix_o=0; E0,75 -> bit per extended table with VP_KBD_EXT_KEYS_EN defined, no change without it.
REQ-031 SHALL cover: scan_vld_i held 1 over 6 bytes -> exactly one accept per 3 cycles; res_n_i pulsed low mid-lookup -> matrix_o=0 and the in-flight byte is lost.
